div32_seq: RTL and testbench

//  Iterative restoring divider for the alu32 datapath: one quotient bit per cycle via a WIDTH-bit subtract.

---
 rtl/div32_seq_pkg.sv | 29 ++
 rtl/div32_seq_div_sub_step.sv | 37 +++
 rtl/div32_seq.sv | 158 +++++++++++++++
 tb/tb_div32_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/div32_seq_pkg.sv
// Shared definitions for the div32_seq iterative divider: default width, FSM encoding,
// and the 4-bit carry-lookahead adder slice used by the trial subtractor.
package div32_seq_pkg;

  localparam int DIV_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Returns {carry_out, sum[3:0]} with all carries computed in lookahead form.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g = a & b;
    p = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

endpackage

// File: rtl/div32_seq_div_sub_step.sv
// Combinational trial subtract a_i - b_i for one restoring-division step, built from
// cla4 slices (b inverted, carry-in 1). borrow_o = 1 when a_i < b_i.
module div32_seq_div_sub_step
  import div32_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  localparam int NCH = (WIDTH + 4) / 4;
  localparam int PW  = NCH * 4;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] nb_ext;
  logic [PW-1:0] sum;
  logic          cy;

  assign a_ext  = PW'(a_i);
  assign nb_ext = ~PW'(b_i);

  always_comb begin
    sum = '0;
    cy  = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      {cy, sum[4*k +: 4]} = cla4(a_ext[4*k +: 4], nb_ext[4*k +: 4], cy);
    end
  end

  // Every bit from WIDTH upward is a copy of the sign; the final carry is its complement.
  assign diff_o   = sum[WIDTH-1:0];
  assign borrow_o = ~cy & (&sum[PW-1:WIDTH]);

endmodule

// File: rtl/div32_seq.sv
// Iterative restoring divider, one quotient bit per cycle. Define DIV_SIGNED_EN to honour
// is_signed (truncating signed division); otherwise every operation is unsigned.
module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, rem_q, rem_d, dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             accept, last, dsr_zero, borrow, take;
  logic [WIDTH-1:0] trial_a, diff, q_step, r_step;
  logic [WIDTH-1:0] mag_dvd, mag_dsr, fin_q, fin_r;

  assign accept   = start && (state_q == IDLE);
  assign last     = (cnt_q == CNT_LAST);
  assign dsr_zero = (divisor == '0);

  // Partial remainder is shifted left with the next dividend bit before the trial subtract.
  assign trial_a = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};

  div32_seq_div_sub_step #(.WIDTH(WIDTH)) u_sub (
    .a_i      (trial_a),
    .b_i      (dsr_q),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  // A set remainder MSB means the shifted value exceeds 2^WIDTH, so it always subtracts.
  assign take   = ~borrow | rem_q[WIDTH-1];
  assign r_step = take ? diff : trial_a;
  assign q_step = {dvd_q[WIDTH-2:0], take};

`ifdef DIV_SIGNED_EN
  logic dvd_neg, dsr_neg, negq_q, negr_q;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dsr_neg = is_signed & divisor[WIDTH-1];
  assign mag_dvd = neg_if(dividend, dvd_neg);
  assign mag_dsr = neg_if(divisor, dsr_neg);
  assign fin_q   = neg_if(q_step, negq_q);
  assign fin_r   = neg_if(r_step, negr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (accept) begin
      negq_q <= dvd_neg ^ dsr_neg;
      negr_q <= dvd_neg;
    end
  end
`else
  logic is_signed_unused;
  assign is_signed_unused = is_signed;
  assign mag_dvd = dividend;
  assign mag_dsr = divisor;
  assign fin_q   = q_step;
  assign fin_r   = r_step;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = dsr_zero ? DONE : CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    dvd_d = dvd_q;
    rem_d = rem_q;
    dsr_d = dsr_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    dbz_d = dbz_q;
    if (accept) begin
      dvd_d = mag_dvd;
      dsr_d = mag_dsr;
      rem_d = '0;
      cnt_d = '0;
      dbz_d = dsr_zero;
      if (dsr_zero) begin
        quo_d = '1;
        rmd_d = dividend;
      end
    end else if (state_q == CALC) begin
      dvd_d = q_step;
      rem_d = r_step;
      if (last) begin
        quo_d = fin_q;
        rmd_d = fin_r;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rmd_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
      dbz_q <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq (WIDTH=32); signed vectors are added when
// DIV_SIGNED_EN is defined.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int          ntests = 0;
  int          nfail  = 0;
  int          n;
  logic [31:0] prev_q = 32'd0;

  div32_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // One full operation: issue start for a single cycle, then wait (bounded) for done.
  task automatic run_op(input string tag, input logic [31:0] dd, input logic [31:0] ds,
                        input logic sg, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int elat);
    int k;
    @(negedge clk);
    dividend  = dd;
    divisor   = ds;
    is_signed = sg;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    if (elat > 1) chk({tag, " held"}, quotient, prev_q);
    k = 1;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'(elat));
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " dbz"}, 32'(div_by_zero), 32'(edz));
    prev_q = eq;
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;

    run_op("100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
    run_op("max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    run_op("5/9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 33);
    run_op("max/big", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, 1'b0, 33);
`ifdef DIV_SIGNED_EN
    run_op("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("s 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    run_op("s min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33);
    run_op("s -5/0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);
`else
    run_op("u sgn ignored", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 33);
`endif

    // start held high across a whole op: the second accept happens only once back in IDLE
    @(negedge clk);
    dividend  = 32'd100;
    divisor   = 32'd7;
    is_signed = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    dividend = 32'd9;
    divisor  = 32'd3;
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b latency1", 32'(n), 32'd33);
    chk("b2b quotient1", quotient, 32'd14);
    @(negedge clk);
    chk("b2b idle gap", 32'(busy), 32'd0);
    @(negedge clk);
    chk("b2b second accept", 32'(busy), 32'd1);
    chk("b2b held", quotient, 32'd14);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b latency2", 32'(n), 32'd33);
    chk("b2b quotient2", quotient, 32'd3);
    chk("b2b remainder2", remainder, 32'd0);
    prev_q = 32'd3;
    @(negedge clk);

    run_op("1234/0", 32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);

    // reset mid-CALC: results from the div-by-zero op must vanish asynchronously
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("accept clears dbz", 32'(div_by_zero), 32'd0);
    chk("accept holds quotient", quotient, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst quotient", quotient, 32'd0);
    chk("midrst remainder", remainder, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("midrst no done", 32'(n), 32'd0);
    prev_q = 32'd0;

    run_op("9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
